// File: rtl/delay_line_probe_meter.sv
// Latency meter for a registered delay line: flushes the line with zeros, injects a
// one-cycle marker, then counts cycles until the marker returns or a timeout expires.
module delay_line_probe_meter #(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  PATTERN      = WIDTH'(8'hA5),
  parameter int unsigned       FLUSH_CYCLES = 200,
  parameter int unsigned       TIMEOUT      = 300,
  parameter int unsigned       CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] echo_in,
  output logic [WIDTH-1:0] probe_out,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] delay_count
);

  typedef enum logic [2:0] {StIdle, StFlush, StSend, StWait, StReport} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_probe, w_probe_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_valid, w_valid_d;
  logic             r_timeout, w_timeout_d;
  logic [CNT_W-1:0] r_count, w_count_d;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_probe_d   = '0;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_valid_d   = r_valid;
    w_timeout_d = r_timeout;
    w_count_d   = r_count;

    case (r_state)
      StIdle, StReport: begin
        if (start) begin
          w_state_d   = StFlush;
          w_cnt_d     = '0;
          w_valid_d   = 1'b0;
          w_timeout_d = 1'b0;
          w_busy_d    = 1'b1;
        end
      end
      StFlush: begin
        // Echo is ignored here so stale markers left in the line drain out unseen.
        if (r_cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
          w_state_d = StSend;
          w_probe_d = PATTERN;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StSend: begin
        w_cnt_d   = CNT_W'(1);
        w_state_d = StWait;
      end
      StWait: begin
        if (echo_in == PATTERN) begin
          w_count_d   = r_cnt;
          w_timeout_d = 1'b0;
          w_done_d    = 1'b1;
          w_valid_d   = 1'b1;
          w_busy_d    = 1'b0;
          w_state_d   = StReport;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_count_d   = '0;
          w_timeout_d = 1'b1;
          w_done_d    = 1'b1;
          w_valid_d   = 1'b1;
          w_busy_d    = 1'b0;
          w_state_d   = StReport;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_probe   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_probe   <= w_probe_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_valid   <= w_valid_d;
      r_timeout <= w_timeout_d;
      r_count   <= w_count_d;
    end
  end

  assign probe_out    = r_probe;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_valid;
  assign timeout      = r_timeout;
  assign delay_count  = r_count;

endmodule

// File: tb/tb_delay_line_probe_meter.sv
// Bench for delay_line_probe_meter: a behavioural shift line of selectable depth feeds
// echo_in; expected results are queued at each start and popped at each done.
module tb_delay_line_probe_meter;

  localparam logic [7:0] PAT   = 8'hA5;
  localparam int         FLUSH = 200;
  localparam int         TMO   = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] echo_in;
  logic [7:0] probe_out;
  logic       busy, done, result_valid, timeout;
  logic [8:0] delay_count;

  logic [7:0] line [0:255];
  logic [7:0] tap;
  int         depth = 60;
  bit         tie_zero = 1'b0;
  bit         preload = 1'b0;
  bit         preload_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {int count; bit to;} exp_t;
  exp_t sb[$];
  exp_t e;

  delay_line_probe_meter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .echo_in      (echo_in),
    .probe_out    (probe_out),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .timeout      (timeout),
    .delay_count  (delay_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++)
        line[i] <= (preload_mode && (i == 10 || i == 40 || i == 70 || i == 100 || i == 119))
                   ? PAT : 8'h00;
    end else begin
      line[0] <= probe_out;
      for (int i = 1; i < 256; i++) line[i] <= line[i-1];
    end
  end

  assign tap = 8'(depth - 1);
  always_comb echo_in = tie_zero ? 8'h00 : line[tap];

  task automatic pulse_start(input int exp_count, input bit exp_to);
    exp_t x;
    x.count = exp_count;
    x.to    = exp_to;
    sb.push_back(x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; reports whether it arrived and how many busy cycles preceded it.
  task automatic wait_done(input int limit, output bit ok, output int busy_cyc);
    ok = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    preload_mode = 1'b0;
    preload = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (probe_out !== 8'h00) begin errors++; $display("FAIL rst_probe: got %0h want 0", probe_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", result_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
    checks++; if (delay_count !== 9'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", delay_count); end
    start = 1'b0;
    preload = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok; int bc;
    depth = 60;
    pulse_start(60, 1'b0);
    wait_done(600, ok, bc);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got none want done"); end
    checks++; if (bc != FLUSH + 1 + 60) begin errors++; $display("FAIL single_busy: got %0d want %0d", bc, FLUSH + 61); end
    checks++; if (delay_count !== 9'(e.count)) begin errors++; $display("FAIL single_count: got %0d want %0d", delay_count, e.count); end
    checks++; if (timeout !== e.to) begin errors++; $display("FAIL single_to: got %0b want %0b", timeout, e.to); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", result_valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_pulse: got %0b want 0", done); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL single_hold: got %0b want 1", result_valid); end
  endtask

  task automatic test_back_to_back();
    int depths [3] = '{1, 90, 180};
    bit ok; int bc;
    for (int k = 0; k < 3; k++) begin
      depth = depths[k];
      pulse_start(depths[k], 1'b0);
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop%0d: got %0b want 0", depths[k], result_valid); end
      wait_done(800, ok, bc);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL b2b_done%0d: got none want done", depths[k]); end
      checks++; if (bc != FLUSH + 1 + depths[k]) begin errors++; $display("FAIL b2b_busy%0d: got %0d want %0d", depths[k], bc, FLUSH + 1 + depths[k]); end
      checks++; if (delay_count !== 9'(e.count)) begin errors++; $display("FAIL b2b_count%0d: got %0d want %0d", depths[k], delay_count, e.count); end
      checks++; if (timeout !== e.to) begin errors++; $display("FAIL b2b_to%0d: got %0b want %0b", depths[k], timeout, e.to); end
    end
  endtask

  task automatic test_stale();
    bit ok; int bc;
    depth = 120;
    preload_mode = 1'b1;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    pulse_start(120, 1'b0);
    wait_done(800, ok, bc);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL stale_done: got none want done"); end
    checks++; if (delay_count !== 9'(e.count)) begin errors++; $display("FAIL stale_count: got %0d want %0d", delay_count, e.count); end
    checks++; if (timeout !== e.to) begin errors++; $display("FAIL stale_to: got %0b want %0b", timeout, e.to); end
  endtask

  task automatic test_timeout();
    bit ok; int bc;
    tie_zero = 1'b1;
    pulse_start(0, 1'b1);
    wait_done(900, ok, bc);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL to_done: got none want done"); end
    checks++; if (bc != FLUSH + 1 + TMO) begin errors++; $display("FAIL to_busy: got %0d want %0d", bc, FLUSH + 1 + TMO); end
    checks++; if (timeout !== e.to) begin errors++; $display("FAIL to_flag: got %0b want %0b", timeout, e.to); end
    checks++; if (delay_count !== 9'(e.count)) begin errors++; $display("FAIL to_count: got %0d want %0d", delay_count, e.count); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %0b want 1", result_valid); end
    tie_zero = 1'b0;
  endtask

  task automatic test_ignore_start();
    bit ok; int bc; int extra;
    depth = 90;
    pulse_start(90, 1'b0);
    repeat (220) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %0b want 1", busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(800, ok, bc);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL ign_done: got none want done"); end
    checks++; if (delay_count !== 9'(e.count)) begin errors++; $display("FAIL ign_count: got %0d want %0d", delay_count, e.count); end
    extra = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_extra: got %0d dones want 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle: got %0b want 0", busy); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ign_sb: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok; int bc;
    depth = 90;
    pulse_start(90, 1'b0);
    repeat (240) @(negedge clk);  // WAIT cycle with counter = 40
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
    checks++; if (probe_out !== 8'h00) begin errors++; $display("FAIL mid_rst_probe: got %0h want 0", probe_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %0b want 0", done); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", result_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL mid_rst_to: got %0b want 0", timeout); end
    checks++; if (delay_count !== 9'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", delay_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy: got %0b want 0", busy); end
    checks++; if (probe_out !== 8'h00) begin errors++; $display("FAIL mid_idle_probe: got %0h want 0", probe_out); end
    pulse_start(90, 1'b0);
    wait_done(800, ok, bc);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL mid_done: got none want done"); end
    checks++; if (bc != FLUSH + 1 + 90) begin errors++; $display("FAIL mid_busy_cyc: got %0d want %0d", bc, FLUSH + 91); end
    checks++; if (delay_count !== 9'(e.count)) begin errors++; $display("FAIL mid_count: got %0d want %0d", delay_count, e.count); end
    checks++; if (timeout !== e.to) begin errors++; $display("FAIL mid_to: got %0b want %0b", timeout, e.to); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stale();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish want finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
